bist_datapath_ctrl: RTL
=======================

Name: bist_datapath_ctrl

Overview:
- Responder to the BIST control FSM. It decodes the 5-bit BIST_CODE state code each cycle and drives the BIST datapath: pattern counter, LFSR pattern source, DUT reset and clock-enable strobes, and response compare with error logging.
- It returns the status flags the FSM branches on: Counter_in, end_flag, log_res_flag, log_clk_en and error_flag.
- It sits between the FSM and the logic under test inside the JTAG BIST wrapper.

Parameters:
- PAT_WIDTH, 8: pattern / LFSR width.
- RESP_WIDTH, 8: DUT response width.
- PAT_NUM, 256: patterns per run; range 2..256.
- RES_PERIOD, 16: logic-reset interval in patterns; must be a power of two.
- LFSR_SEED, 8'h01: LFSR value after clear; must be nonzero.

Ports:
- BIST_clk  in  1  clock; all logic on the rising edge.
- res  in  1  reset, synchronous, active-high.
- BIST_CODE  in  5  FSM state code.
- resp_in  in  RESP_WIDTH  DUT response.
- exp_in  in  RESP_WIDTH  golden response.
- x_mask_in  in  1  high = current pattern not capturable.
- Counter_in  out  8  pattern counter, to the FSM.
- end_flag, log_res_flag, log_clk_en, error_flag  out  1 each  FSM branch flags (registered).
- pattern_out  out  PAT_WIDTH  LFSR pattern to DUT.
- pat_load, dut_res, dut_clk_en, shift_en, update_en  out  1 each  single-cycle strobes.
- err_pattern  out  8  index of the first failing pattern.
- bist_done, bist_pass  out  1 each  sticky run status.

Behaviour:
- Reset: synchronous, active-high on res. Clock is BIST_clk; there is exactly one clock. res=1 on a rising edge sets every output to 0, sets Counter_in to 0 and sets the LFSR to LFSR_SEED. Mid-run reset aborts immediately, with no partial updates.
- Strobes are combinational decodes of BIST_CODE, high only in that code's cycle:
  - shift_en = code 2
  - update_en = code 3
  - pat_load = code 5
  - dut_res = code 8
  - dut_clk_en = code 10
- Registered actions, by code present during the cycle (taking effect at that cycle's edge):
  - Code 4: Counter_in<=0, LFSR<=LFSR_SEED; clear all four flags, err_pattern, bist_done and bist_pass.
  - Code 6: evaluate the first three flags:
    - end_flag <= (Counter_in == PAT_NUM-1)
    - log_res_flag <= ((Counter_in+1) mod RES_PERIOD == 0)
    - log_clk_en <= ~x_mask_in
  - Code 9: Counter_in <= Counter_in+1, wrapping at 255 to 0. LFSR advances one step: shift left, bit0 = q7^q5^q4^q3.
  - Code 11: error_flag <= (resp_in != exp_in).
  - Code 13: err_pattern <= Counter_in.
  - Code 14: bist_done<=1, bist_pass<=0.
  - Code 15: bist_done<=1, bist_pass<=1.
  - Codes 0, 1, 2, 3, 5, 7, 8, 10, 12, 16: registers hold.
- Flag timing: flags are valid for the whole of code 7 (first three) and code 12 (error_flag). They hold until re-evaluated or cleared.
- Latency: a flag is visible exactly 1 cycle after its evaluation code.
- pattern_out = LFSR register; it changes only on codes 4, 9 and reset.
- Undefined codes 17–31: no strobes, registers hold, no error indication.
- Simultaneous res and any code: res wins.
- bist_done and bist_pass are sticky until code 4 or res.

Decomposition:
- Shared package bist_pkg holds the BIST_CODE constants 0–16 (CODE_IDLE … CODE_FINISH), used by both the FSM and this block. It also holds the default LFSR taps.
- One sub-module, bist_lfsr: load-seed, step enable, PAT_WIDTH output.

Test Plan:
- Reset: drive codes 4→9, then res=1 for one edge → Counter_in=0, pattern_out=8'h01, all flags and strobes 0.
- Pattern advance: code 4, then code 9 ×3 → Counter_in=3, pattern_out=8'h08. Code 5 asserts pat_load for exactly one cycle.
- Flags with PAT_NUM=256, RES_PERIOD=16:
  - Counter_in=15, code 6 → log_res_flag=1, end_flag=0 during code 7.
  - Counter_in=255, code 6 → end_flag=1.
  - x_mask_in=1 at code 6 → log_clk_en=0.
- Compare and log:
  - Counter_in=0x2A, resp_in=8'h5A, exp_in=8'h5B, code 11 → error_flag=1 in code 12.
  - Then codes 13, 14 → err_pattern=0x2A, bist_done=1, bist_pass=0.
- Pass path: error-free compare (resp_in=exp_in), then code 15 → error_flag=0, bist_done=1, bist_pass=1. Code 16 holds both.
- Robustness: code 20 → no strobes, no state change.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared BIST definitions: FSM state codes and the default LFSR taps.
// Imported by the BIST FSM and by the datapath responder.
package bist_pkg;

    // State codes the BIST FSM presents on BIST_CODE.
    typedef enum logic [4:0] {
        CODE_IDLE    = 5'd0,
        CODE_INIT    = 5'd1,
        CODE_SHIFT   = 5'd2,
        CODE_UPDATE  = 5'd3,
        CODE_CLEAR   = 5'd4,
        CODE_LOAD    = 5'd5,
        CODE_EVAL    = 5'd6,
        CODE_BRANCH  = 5'd7,
        CODE_DUT_RES = 5'd8,
        CODE_NEXT    = 5'd9,
        CODE_DUT_CLK = 5'd10,
        CODE_COMPARE = 5'd11,
        CODE_ERR_CHK = 5'd12,
        CODE_LOG     = 5'd13,
        CODE_DONE_NG = 5'd14,
        CODE_DONE_OK = 5'd15,
        CODE_FINISH  = 5'd16
    } bist_code_e;

    // Feedback taps q7^q5^q4^q3 for the 8-bit pattern source.
    localparam logic [7:0] LFSR_TAPS_DEF = 8'hB8;

endpackage

// File: rtl/bist_datapath_ctrl_if.sv
// Bundle between the BIST FSM (master) and the datapath responder (slave):
// state code and compare inputs one way, flags, strobes and status back.
interface bist_datapath_ctrl_if #(
    parameter int PAT_WIDTH  = 8,
    parameter int RESP_WIDTH = 8
);
    logic [4:0]            BIST_CODE;
    logic [RESP_WIDTH-1:0] resp_in;
    logic [RESP_WIDTH-1:0] exp_in;
    logic                  x_mask_in;
    logic [7:0]            Counter_in;
    logic                  end_flag;
    logic                  log_res_flag;
    logic                  log_clk_en;
    logic                  error_flag;
    logic [PAT_WIDTH-1:0]  pattern_out;
    logic                  pat_load;
    logic                  dut_res;
    logic                  dut_clk_en;
    logic                  shift_en;
    logic                  update_en;
    logic [7:0]            err_pattern;
    logic                  bist_done;
    logic                  bist_pass;

    modport master (
        output BIST_CODE, resp_in, exp_in, x_mask_in,
        input  Counter_in, end_flag, log_res_flag, log_clk_en,
        input  error_flag, pattern_out, pat_load, dut_res,
        input  dut_clk_en, shift_en, update_en, err_pattern,
        input  bist_done, bist_pass
    );

    modport slave (
        input  BIST_CODE, resp_in, exp_in, x_mask_in,
        output Counter_in, end_flag, log_res_flag, log_clk_en,
        output error_flag, pattern_out, pat_load, dut_res,
        output dut_clk_en, shift_en, update_en, err_pattern,
        output bist_done, bist_pass
    );
endinterface

// File: rtl/bist_lfsr.sv
// Fibonacci LFSR pattern source: shift left, feedback into bit 0.
// Ports: i_clk, i_rst (sync, to seed), i_load (seed), i_step, o_q.
module bist_lfsr
    import bist_pkg::*;
#(
    parameter int                   PAT_WIDTH = 8,
    parameter logic [PAT_WIDTH-1:0] SEED      = 8'h01,
    parameter logic [PAT_WIDTH-1:0] TAPS      = LFSR_TAPS_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_load,
    input  logic                 i_step,
    output logic [PAT_WIDTH-1:0] o_q
);
    logic [PAT_WIDTH-1:0] r_q;
    logic                 w_fb;

    assign w_fb = ^(r_q & TAPS);
    assign o_q  = r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_load) begin
            r_q <= SEED;
        end else if (i_step) begin
            r_q <= {r_q[PAT_WIDTH-2:0], w_fb};
        end
    end
endmodule

// File: rtl/bist_datapath_ctrl.sv
// BIST datapath responder: decodes BIST_CODE into strobes, pattern counter,
// LFSR, flags and error log. Ports: BIST_clk, res (sync high), bif (slave).
module bist_datapath_ctrl
    import bist_pkg::*;
#(
    parameter int                   PAT_WIDTH  = 8,
    parameter int                   RESP_WIDTH = 8,
    parameter int                   PAT_NUM    = 256,
    parameter int                   RES_PERIOD = 16,
    parameter logic [PAT_WIDTH-1:0] LFSR_SEED  = 8'h01
) (
    input logic                  BIST_clk,
    input logic                  res,
    bist_datapath_ctrl_if.slave  bif
);
    localparam logic [7:0] END_CNT  = 8'(PAT_NUM - 1);
    localparam logic [8:0] RES_MASK = 9'(RES_PERIOD - 1);

    logic [7:0] r_cnt;
    logic       r_end;
    logic       r_log_res;
    logic       r_log_clk;
    logic       r_err;
    logic [7:0] r_err_pat;
    logic       r_done;
    logic       r_pass;

    logic       w_clear;
    logic       w_step;
    logic [8:0] w_cnt_inc;
    logic [PAT_WIDTH-1:0] w_pat;

    assign w_clear   = (bif.BIST_CODE == CODE_CLEAR);
    assign w_step    = (bif.BIST_CODE == CODE_NEXT);
    // Counter+1 kept 9 bits wide so 255+1 is a multiple of RES_PERIOD.
    assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;

    // Strobes are forced low during reset so res wins over any code.
    assign bif.shift_en   = !res && (bif.BIST_CODE == CODE_SHIFT);
    assign bif.update_en  = !res && (bif.BIST_CODE == CODE_UPDATE);
    assign bif.pat_load   = !res && (bif.BIST_CODE == CODE_LOAD);
    assign bif.dut_res    = !res && (bif.BIST_CODE == CODE_DUT_RES);
    assign bif.dut_clk_en = !res && (bif.BIST_CODE == CODE_DUT_CLK);

    always_ff @(posedge BIST_clk) begin
        if (res) begin
            r_cnt     <= '0;
            r_end     <= 1'b0;
            r_log_res <= 1'b0;
            r_log_clk <= 1'b0;
            r_err     <= 1'b0;
            r_err_pat <= '0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            case (bif.BIST_CODE)
                CODE_CLEAR: begin
                    r_cnt     <= '0;
                    r_end     <= 1'b0;
                    r_log_res <= 1'b0;
                    r_log_clk <= 1'b0;
                    r_err     <= 1'b0;
                    r_err_pat <= '0;
                    r_done    <= 1'b0;
                    r_pass    <= 1'b0;
                end
                CODE_EVAL: begin
                    r_end     <= (r_cnt == END_CNT);
                    r_log_res <= ((w_cnt_inc & RES_MASK) == 9'd0);
                    r_log_clk <= ~bif.x_mask_in;
                end
                CODE_NEXT:    r_cnt     <= r_cnt + 8'd1;
                CODE_COMPARE: r_err     <= (bif.resp_in != bif.exp_in);
                CODE_LOG:     r_err_pat <= r_cnt;
                CODE_DONE_NG: begin
                    r_done <= 1'b1;
                    r_pass <= 1'b0;
                end
                CODE_DONE_OK: begin
                    r_done <= 1'b1;
                    r_pass <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    bist_lfsr #(
        .PAT_WIDTH (PAT_WIDTH),
        .SEED      (LFSR_SEED)
    ) u_lfsr (
        .i_clk  (BIST_clk),
        .i_rst  (res),
        .i_load (w_clear),
        .i_step (w_step),
        .o_q    (w_pat)
    );

    assign bif.Counter_in   = r_cnt;
    assign bif.end_flag     = r_end;
    assign bif.log_res_flag = r_log_res;
    assign bif.log_clk_en   = r_log_clk;
    assign bif.error_flag   = r_err;
    assign bif.pattern_out  = w_pat;
    assign bif.err_pattern  = r_err_pat;
    assign bif.bist_done    = r_done;
    assign bif.bist_pass    = r_pass;
endmodule
